// File: rtl/mcd_pkg.sv
// Shared types and constants for the multi-cycle 16-bit-ISA datapath.
package mcd_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_ADD2  = 2'b11;

    localparam int OPC_HI = 15, OPC_LO = 12;
    localparam int RS_HI  = 11, RS_LO  = 9;
    localparam int RT_HI  = 8,  RT_LO  = 6;
    localparam int RD_HI  = 5,  RD_LO  = 3;
    localparam int IMM_HI = 5,  IMM_LO = 0;
    localparam int JT_HI  = 11, JT_LO  = 0;

    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

endpackage

// File: rtl/mcd_regfile.sv
// Eight-entry general register file: two combinational reads, one clocked write.
module mcd_regfile
    import mcd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [REG_N];

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB,
// with handshaked instruction and data memories and an external control unit.
module multicycle_datapath
    import mcd_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [1:0]        alu_op,
    output logic [3:0]        opcode,
    output logic [PC_W-1:0]   pc_o,
    output logic              retire
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc2, br_off;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] rs_val, rt_val, imm, alu_b, alu_y, wb_data;
    logic [2:0]        alu_sel;
    logic [REG_AW-1:0] dest_idx;
    logic              zero, retire_d;

    function automatic logic [DATA_W-1:0] alu(input logic [2:0] sel,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
        case (sel)
            ALU_SUB: return x - y;
            ALU_NOT: return ~x;
            ALU_SLL: return x << y[3:0];
            ALU_SRL: return x >> y[3:0];
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {{(DATA_W-1){1'b0}}, ($signed(x) < $signed(y))};
            default: return x + y;
        endcase
    endfunction

    mcd_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (ir_q[RS_HI:RS_LO]),
        .ra2_i (ir_q[RT_HI:RT_LO]),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (state_q == S_WB),
        .wa_i  (dest_idx),
        .wd_i  (wb_data)
    );

    assign imm      = {{(DATA_W-6){ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO]};
    assign br_off   = {{(PC_W-7){ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO], 1'b0};
    assign pc2      = pc_q + PC_W'(2);
    assign dest_idx = reg_dst ? ir_q[RD_HI:RD_LO] : ir_q[RT_HI:RT_LO];
    assign wb_data  = mem_to_reg ? mdr_q : aluout_q;
    assign alu_b    = alu_src ? imm : b_q;
    assign alu_y    = alu(alu_sel, a_q, alu_b);
    assign zero     = (alu_y == '0);

    always_comb begin
        alu_sel = ALU_ADD;
        case (alu_op)
            AOP_SUB:           alu_sel = ALU_SUB;
            AOP_FUNCT:         alu_sel = ir_q[OPC_LO+2:OPC_LO];
            AOP_ADD, AOP_ADD2: alu_sel = ALU_ADD;
            default:           alu_sel = ALU_ADD;
        endcase
    end

    // Handshake outputs are gated by rst_n so they drop the moment reset asserts.
    assign imem_req   = rst_n && (state_q == S_FETCH);
    assign dmem_req   = rst_n && (state_q == S_MEM);
    assign dmem_we    = dmem_req && mem_write;
    assign retire     = rst_n && retire_d;
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;
    assign opcode     = ir_q[OPC_HI:OPC_LO];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluout_d = alu_y;
                if (jump) begin
                    pc_d = {pc2[PC_W-1:13], ir_q[JT_HI:JT_LO], 1'b0};
                end else if ((bne && !zero) || (beq && zero)) begin
                    pc_d = pc2 + br_off;
                end else begin
                    pc_d = pc2;
                end
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else if (reg_write) begin
                    state_d = S_WB;
                end else begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    mdr_d = dmem_rdata;
                    if (reg_write) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: the bench acts as control unit and both memories, and compares
// the datapath against an instruction-level reference model of registers and PC.
module tb_multicycle_datapath;

    localparam int DW = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire;
    logic [PW-1:0] imem_addr, pc_o;
    logic [15:0]   imem_rdata;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0]    alu_op;
    logic [3:0]    opcode;

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(DW), .PC_W(PW), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_op(alu_op), .opcode(opcode), .pc_o(pc_o), .retire(retire)
    );

    typedef struct packed {
        logic       jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] mReg [8];
    logic [PW-1:0] mPc;
    int            lastLat;
    logic [DW-1:0] lastWdata;
    logic          lastWe;

    // Bench-side control unit: 0-7 R-type (funct = opcode), 8 addi, 9 lw, A sw,
    // B beq, C bne, D jump, E add-imm via class 11, F sub-imm.
    function automatic ctrl_t ctrlFor(input logic [3:0] op);
        ctrl_t c = '0;
        case (op)
            4'h8: begin c.alu_src = 1; c.reg_write = 1; end
            4'h9: begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; end
            4'hA: begin c.alu_src = 1; c.mem_write = 1; end
            4'hB: begin c.beq = 1; c.alu_op = 2'b01; end
            4'hC: begin c.bne = 1; c.alu_op = 2'b01; end
            4'hD: c.jump = 1;
            4'hE: begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 2'b11; end
            4'hF: begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 2'b01; end
            default: begin c.alu_op = 2'b10; c.reg_dst = 1; c.reg_write = 1; end
        endcase
        return c;
    endfunction

    function automatic logic [DW-1:0] refAlu(input logic [1:0] cls, input logic [3:0] op,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        int kind;
        kind = (cls == 2'b10) ? int'(op[2:0]) : ((cls == 2'b01) ? 1 : 0);
        case (kind)
            1:       return a - b;
            2:       return ~a;
            3:       return a << (b % 16);
            4:       return a >> (b % 16);
            5:       return a & b;
            6:       return a | b;
            7:       return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

    task automatic applyStimulus(input ctrl_t c);
        jump = c.jump; beq = c.beq; bne = c.bne; mem_read = c.mem_read; mem_write = c.mem_write;
        alu_src = c.alu_src; reg_dst = c.reg_dst; mem_to_reg = c.mem_to_reg;
        reg_write = c.reg_write; alu_op = c.alu_op;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mReg[i] = '0;
        mPc = '0;
    endtask

    // Runs one instruction with the given memory latencies and checks it against the model.
    task automatic runInstr(input logic [15:0] instr, input ctrl_t c, input int ilat,
                            input int dlat, input logic [DW-1:0] rdata);
        logic [DW-1:0] a, b, imm, y;
        logic [PW-1:0] expPc;
        logic [2:0]    dest;
        logic          memAcc, zero;
        int            immVal, expLat, cyc, fetchCyc, memCyc, seqBad, dmemBad;
        bit            done;
        a      = mReg[instr[11:9]];
        b      = mReg[instr[8:6]];
        immVal = instr[5] ? int'(instr[5:0]) - 64 : int'(instr[5:0]);
        imm    = DW'(immVal);
        y      = refAlu(c.alu_op, instr[15:12], a, c.alu_src ? imm : b);
        zero   = (y == '0);
        if (c.jump) expPc = PW'((int'(mPc) + 2) / 8192 * 8192 + int'(instr[11:0]) * 2);
        else if ((c.bne && !zero) || (c.beq && zero)) expPc = PW'(int'(mPc) + 2 + 2 * immVal);
        else expPc = PW'(int'(mPc) + 2);
        memAcc = c.mem_read || c.mem_write;
        expLat = ilat + 3 + (memAcc ? dlat + 1 : 0) + (c.reg_write ? 1 : 0);
        dest   = c.reg_dst ? instr[5:3] : instr[8:6];
        applyStimulus(c);
        cyc = 0; done = 0; fetchCyc = 0; memCyc = 0; seqBad = 0; dmemBad = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (imem_req) begin
                if (imem_addr !== mPc) seqBad++;
                imem_rdata = instr;
                imem_ready = (fetchCyc >= ilat);
                fetchCyc++;
            end else begin
                imem_ready = 1'b0;
                if (opcode !== instr[15:12]) seqBad++;
            end
            if (dmem_req) begin
                if (dmem_we !== c.mem_write || dmem_addr !== y || dmem_wdata !== b) dmemBad++;
                lastWdata  = dmem_wdata;
                lastWe     = dmem_we;
                dmem_rdata = rdata;
                dmem_ready = (memCyc >= dlat);
                memCyc++;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (retire === 1'b1) done = 1;
        end
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        lastLat = cyc;
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL retire_timeout instr=%h got no retire, required retire within 200 cycles", instr);
        end
        checks++;
        if (cyc !== expLat) begin
            failures++;
            $display("[TB] FAIL latency instr=%h got=%0d required=%0d", instr, cyc, expLat);
        end
        checks++;
        if (fetchCyc !== ilat + 1) begin
            failures++;
            $display("[TB] FAIL fetch_cycles instr=%h got=%0d required=%0d", instr, fetchCyc, ilat + 1);
        end
        checks++;
        if (memCyc !== (memAcc ? dlat + 1 : 0)) begin
            failures++;
            $display("[TB] FAIL mem_cycles instr=%h got=%0d required=%0d", instr, memCyc, memAcc ? dlat + 1 : 0);
        end
        checks++;
        if (seqBad !== 0) begin
            failures++;
            $display("[TB] FAIL fetch_addr_opcode instr=%h bad_cycles=%0d required=0 (pc=%h)", instr, seqBad, mPc);
        end
        if (memAcc) begin
            checks++;
            if (dmemBad !== 0) begin
                failures++;
                $display("[TB] FAIL dmem_fields instr=%h bad_cycles=%0d got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                         instr, dmemBad, lastWe, dmem_addr, lastWdata, c.mem_write, y, b);
            end
        end
        checks++;
        if (pc_o !== expPc) begin
            failures++;
            $display("[TB] FAIL next_pc instr=%h got=%h required=%h", instr, pc_o, expPc);
        end
        checks++;
        if (retire !== 1'b0) begin
            failures++;
            $display("[TB] FAIL retire_pulse instr=%h got=%b required=0", instr, retire);
        end
        if (c.reg_write) mReg[dest] = c.mem_to_reg ? rdata : y;
        mPc = expPc;
    endtask

    task automatic test_reset();
        applyStimulus('0);
        imem_ready = 0; dmem_ready = 0; imem_rdata = '0; dmem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_imem_req got=%b required=0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_dmem_req got=%b required=0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_dmem_we got=%b required=0", dmem_we); end
        checks++; if (retire !== 1'b0) begin failures++; $display("[TB] FAIL rst_retire got=%b required=0", retire); end
        checks++; if (pc_o !== 16'h0000) begin failures++; $display("[TB] FAIL rst_pc got=%h required=0000", pc_o); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_imem_req got=%b required=1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL post_rst_imem_addr got=%h required=0000", imem_addr); end
        resetModel();
    endtask

    task automatic test_add();
        runInstr({4'h8, 3'd0, 3'd1, 6'd5}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'h8, 3'd0, 3'd2, 6'd7}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'h0, 3'd1, 3'd2, 3'd3, 3'd0}, ctrlFor(4'h0), 0, 0, '0);
        checks++; if (lastLat !== 4) begin failures++; $display("[TB] FAIL add_latency got=%0d required=4", lastLat); end
        checks++; if (pc_o !== 16'h0006) begin failures++; $display("[TB] FAIL add_pc got=%h required=0006", pc_o); end
        runInstr({4'hA, 3'd0, 3'd3, 6'd0}, ctrlFor(4'hA), 0, 0, '0);
        checks++; if (lastWdata !== 32'd12) begin failures++; $display("[TB] FAIL add_result got=%h required=0000000c", lastWdata); end
    endtask

    task automatic test_lw_wait();
        runInstr({4'h9, 3'd0, 3'd4, 6'd0}, ctrlFor(4'h9), 3, 3, 32'h0000_BEEF);
        checks++; if (lastLat !== 11) begin failures++; $display("[TB] FAIL lw_latency got=%0d required=11", lastLat); end
        runInstr({4'hA, 3'd0, 3'd4, 6'd0}, ctrlFor(4'hA), 0, 0, '0);
        checks++; if (lastWdata !== 32'h0000_BEEF) begin failures++; $display("[TB] FAIL lw_value got=%h required=0000beef", lastWdata); end
    endtask

    task automatic test_branch();
        runInstr({4'h8, 3'd0, 3'd5, 6'd9}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'h8, 3'd0, 3'd6, 6'd9}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'hD, 12'h008}, ctrlFor(4'hD), 1, 0, '0);
        checks++; if (pc_o !== 16'h0010) begin failures++; $display("[TB] FAIL jump_to_10 got=%h required=0010", pc_o); end
        runInstr({4'hB, 3'd5, 3'd6, 6'h3E}, ctrlFor(4'hB), 0, 0, '0);
        checks++; if (pc_o !== 16'h000E) begin failures++; $display("[TB] FAIL beq_taken got=%h required=000e", pc_o); end
        checks++; if (lastLat !== 3) begin failures++; $display("[TB] FAIL beq_latency got=%0d required=3", lastLat); end
        runInstr({4'h8, 3'd0, 3'd6, 6'd3}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'hB, 3'd5, 3'd6, 6'h3E}, ctrlFor(4'hB), 0, 0, '0);
        checks++; if (pc_o !== 16'h0012) begin failures++; $display("[TB] FAIL beq_not_taken got=%h required=0012", pc_o); end
    endtask

    task automatic test_jump_priority();
        ctrl_t c;
        runInstr({4'hD, 12'hFFF}, ctrlFor(4'hD), 0, 0, '0);
        runInstr({4'h8, 3'd0, 3'd7, 6'd1}, ctrlFor(4'h8), 0, 0, '0);
        runInstr({4'hD, 12'hFFF}, ctrlFor(4'hD), 0, 0, '0);
        runInstr({4'h8, 3'd0, 3'd7, 6'd1}, ctrlFor(4'h8), 0, 0, '0);
        checks++; if (pc_o !== 16'h4000) begin failures++; $display("[TB] FAIL reach_4000 got=%h required=4000", pc_o); end
        c = ctrlFor(4'hD);
        c.beq = 1; c.bne = 1; c.alu_op = 2'b01;
        runInstr({4'hD, 12'h123}, c, 0, 0, '0);
        checks++; if (pc_o !== 16'h4246) begin failures++; $display("[TB] FAIL jump_priority got=%h required=4246", pc_o); end
    endtask

    task automatic test_sw_both();
        ctrl_t c;
        logic [DW-1:0] v;
        v = DW'($urandom) | 32'h8000_0001;
        runInstr({4'h9, 3'd0, 3'd2, 6'd0}, ctrlFor(4'h9), 0, 0, v);
        c = ctrlFor(4'hA);
        c.mem_read = 1; c.mem_to_reg = 1;
        runInstr({4'hA, 3'd0, 3'd2, 6'd4}, c, 0, 1, 32'h1234_5678);
        checks++; if (lastWe !== 1'b1) begin failures++; $display("[TB] FAIL both_we got=%b required=1", lastWe); end
        checks++; if (lastWdata !== v) begin failures++; $display("[TB] FAIL both_wdata got=%h required=%h", lastWdata, v); end
        checks++; if (lastLat !== 5) begin failures++; $display("[TB] FAIL both_latency got=%0d required=5", lastLat); end
        runInstr({4'hA, 3'd0, 3'd2, 6'd0}, ctrlFor(4'hA), 0, 0, '0);
        checks++; if (lastWdata !== v) begin failures++; $display("[TB] FAIL both_no_gpr_write got=%h required=%h", lastWdata, v); end
    endtask

    task automatic test_reset_mid_mem();
        applyStimulus(ctrlFor(4'hA));
        @(negedge clk); imem_rdata = {4'hA, 3'd0, 3'd1, 6'd0}; imem_ready = 1'b1;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); dmem_ready = 1'b0;
        checks++; if (!(dmem_req === 1'b1 && dmem_we === 1'b1)) begin failures++; $display("[TB] FAIL mid_mem_setup got req=%b we=%b required 1 1", dmem_req, dmem_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL abort_dmem_req got=%b required=0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_dmem_we got=%b required=0", dmem_we); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL abort_imem_req got=%b required=0", imem_req); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL rerst_imem_req got=%b required=1", imem_req); end
        checks++; if (pc_o !== 16'h0000) begin failures++; $display("[TB] FAIL rerst_pc got=%h required=0000", pc_o); end
        resetModel();
        for (int i = 0; i < 8; i++) begin
            runInstr({4'hA, 3'd0, 3'(i), 6'd0}, ctrlFor(4'hA), 0, 0, '0);
            checks++;
            if (lastWdata !== '0) begin failures++; $display("[TB] FAIL rerst_gpr%0d got=%h required=0", i, lastWdata); end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            runInstr({op, 12'($urandom)}, ctrlFor(op), $urandom_range(0, 3), $urandom_range(0, 3), DW'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jump_priority();
        test_sw_both();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
